adc_serial_responder: RTL and testbench
=======================================

Name: adc_serial_responder

Overview:
- Emulates the board's 8-channel, 12-bit serial ADC device on the adc_sclk/adc_cs_n/adc_din/adc_dout pins.
- Lets the Avalon ADC controller be exercised in simulation and in FPGA loopback without the real converter.
- Per-channel sample values are programmed by the processor through a zero-wait Avalon-MM slave.
- Channel selection is pipelined one frame, as on the real device.

Parameters:
- FRAME_BITS, 16, sclk rising edges per valid frame.
- SYNC_STAGES, 2, synchronizer flops on adc_sclk, adc_cs_n and adc_din (minimum 2).
- RESET_CHANNEL, 3'd0, channel converted in the first frame after reset.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- read  in  1  Avalon read strobe.
- write  in  1  Avalon write strobe.
- address  in  3  channel register index 0-7.
- writedata  in  32  bits [11:0] = sample value; others ignored.
- readdata  out  32  {20'b0, value[address]} while read, else 0; combinational, no waitrequest.
- adc_sclk  in  1  serial clock from controller (asynchronous to clock).
- adc_cs_n  in  1  frame select, active-low.
- adc_din  in  1  control word from controller.
- adc_dout  out  1  registered serial data to controller.
- frame_count  out  16  completed valid frames; wraps 0xFFFF->0.
- frame_error  out  1  one-cycle pulse on aborted frame.

Behaviour:
- Reset: adc_dout=0, frame_error=0, frame_count=0, all value[0..7]=0, next_ch=RESET_CHANNEL, state IDLE.
- Reset synchronizer values: cs_n=1, sclk=0, din=0. Reset mid-frame abandons the frame.
- If cs_n is low at reset release, nothing happens until a fresh cs_n falling edge.
- Edges are detected on synchronized signals. Pin-to-action latency is SYNC_STAGES+1 clocks.
- Avalon write: value[address] <= writedata[11:0] on the clock edge.
- tx word: {1'b0, ch[2:0], value[ch][11:0]}, MSB first.
- rx word: bit15 = WRITE, bits12:10 = next channel; other bits ignored.
- IDLE:
  - adc_dout=0.
  - On cs_n fall: snapshot tx from next_ch and its value, drive adc_dout=tx[15], clear bit_cnt, go to SHIFT.
  - An Avalon write in the same cycle is not seen by the snapshot.
- SHIFT:
  - On sclk rise: rx <= {rx[14:0], din}, bit_cnt++.
  - On sclk fall, only after ≥1 rise and bit_cnt<FRAME_BITS: shift tx left, adc_dout=new tx[15].
  - When bit_cnt reaches FRAME_BITS: go to DONE and set adc_dout=0.
  - On cs_n rise before FRAME_BITS: frame_error=1 for exactly one cycle, rx discarded, next_ch and frame_count unchanged, go to IDLE.
- DONE:
  - Extra sclk edges are ignored and adc_dout stays 0.
  - On cs_n rise: if rx[15]=1, next_ch <= rx[12:10]; frame_count++; go to IDLE.
- Simultaneous sclk and cs_n edges in one synchronized cycle: the cs_n edge wins.
- An Avalon write during a frame affects only later frames.
- Reads have no side effects.

Test Plan:
- Write 0xFFFABC to address 3, then read address 3 -> readdata=0x00000ABC; read address 2 -> 0x00000000.
- After reset, value[0]=0x123, value[3]=0xABC:
  - Frame 1 with din=0x8C00 -> dout word 0x0123, frame_count=1.
  - Frame 2 with din=0x0000 -> dout word 0x3ABC, frame_count=2.
  - Frame 3 -> dout 0x3ABC again, because the WRITE bit was 0.
- Frame with cs_n raised after 9 sclk rises -> frame_error high for 1 cycle, frame_count unchanged; next full frame returns the previous channel.
- Avalon write value[3]=0x555 after 4 sclk rises of a frame converting ch3 -> that frame returns 0x3ABC, the next returns 0x3555.
- Assert reset after 6 sclk rises -> adc_dout=0, frame_count=0, next_ch=0, values 0; cs_n still low yields no dout activity until cs_n goes high then low.
- Run 0xFFFF+1 valid frames (forced counter preload allowed) -> frame_count wraps to 0x0000; frame with 20 sclk rises -> 16-bit word then dout=0, no frame_error.

Source files
------------

// File: rtl/adc_serial_responder_if.sv
// -----------------------------------------------------------------------------
// adc_serial_responder_if
//
// Zero-wait Avalon-MM register bus used by the processor to program the
// per-channel sample values of the ADC responder.
//
//   read       master -> slave   read strobe
//   write      master -> slave   write strobe
//   address    master -> slave   channel register index 0-7
//   writedata  master -> slave   bits [11:0] = sample value
//   readdata   slave  -> master  {20'b0, value[address]} while read, else 0
// -----------------------------------------------------------------------------
interface adc_serial_responder_if;
  logic        read;
  logic        write;
  logic [2:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output read, write, address, writedata,
    input  readdata
  );

  modport slave (
    input  read, write, address, writedata,
    output readdata
  );
endinterface

// File: rtl/adc_serial_responder.sv
// -----------------------------------------------------------------------------
// adc_serial_responder
//
// Emulates an 8-channel, 12-bit serial ADC so the ADC controller can be run in
// simulation or FPGA loopback without the real converter. Sample values per
// channel come from an Avalon-MM register file; the channel converted in a
// frame is the one requested by the previous frame's control word.
//
// Ports
//   clock, reset   system clock, synchronous active-high reset
//   avs            Avalon-MM slave (read/write/address/writedata/readdata)
//   adc_sclk       serial clock from the controller (asynchronous)
//   adc_cs_n       frame select, active-low (asynchronous)
//   adc_din        control word from the controller (asynchronous)
//   adc_dout       registered serial data back to the controller
//   frame_count    number of completed valid frames, wraps at 16 bits
//   frame_error    one-cycle pulse when a frame is aborted early
//
// Serial words
//   tx: {1'b0, ch[2:0], value[ch][11:0]}, MSB first, shifted on sclk fall
//   rx: bit15 = WRITE, bits 12:10 = next channel, captured on sclk rise
// -----------------------------------------------------------------------------
module adc_serial_responder #(
  parameter int         FRAME_BITS    = 16,
  parameter int         SYNC_STAGES   = 2,
  parameter logic [2:0] RESET_CHANNEL = 3'd0
) (
  input  logic                    clock,
  input  logic                    reset,
  adc_serial_responder_if.slave   avs,
  input  logic                    adc_sclk,
  input  logic                    adc_cs_n,
  input  logic                    adc_din,
  output logic                    adc_dout,
  output logic [15:0]             frame_count,
  output logic                    frame_error
);

  localparam int CNT_W  = $clog2(FRAME_BITS + 1);
  localparam int FILL_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                 state_q,       state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q,   sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q,     cs_sync_d;
  logic [SYNC_STAGES-1:0] din_sync_q,    din_sync_d;
  logic                   sclk_prev_q,   sclk_prev_d;
  logic                   cs_prev_q,     cs_prev_d;
  logic [FILL_W-1:0]      fill_q,        fill_d;
  logic                   armed_q,       armed_d;
  logic [15:0]            tx_q,          tx_d;
  logic [15:0]            rx_q,          rx_d;
  logic [CNT_W-1:0]       bit_cnt_q,     bit_cnt_d;
  logic [2:0]             next_ch_q,     next_ch_d;
  logic [15:0]            frame_count_q, frame_count_d;
  logic                   dout_q,        dout_d;
  logic                   frame_error_q, frame_error_d;
  logic [11:0]            value_q [8];
  logic [11:0]            value_d [8];

  logic sclk_s, cs_s, din_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic last_rise;
  logic unused_writedata;

  assign unused_writedata = ^avs.writedata[31:12];

  // Synchronizer outputs and edge detection on the synchronized pins.
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign din_s     = din_sync_q[SYNC_STAGES-1];
  assign sclk_rise =  sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s &  sclk_prev_q;
  assign cs_rise   =  cs_s   & ~cs_prev_q;
  // A falling cs_n only starts a frame once cs_n has been seen high on a real
  // pin sample after reset; otherwise a pin held low through reset would look
  // like a fresh falling edge when the chain (reset high) flushes.
  assign cs_fall   = ~cs_s   &  cs_prev_q & armed_q;
  assign last_rise = sclk_rise && (bit_cnt_q == CNT_W'(FRAME_BITS - 1));

  assign avs.readdata = avs.read ? {20'b0, value_q[avs.address]} : 32'b0;
  assign adc_dout     = dout_q;
  assign frame_count  = frame_count_q;
  assign frame_error  = frame_error_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: every flop is written with <= so all registers update together from
  // the values computed before the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      // cs_n resets high so an idle bus does not produce a phantom edge.
      sclk_sync_q   <= '0;
      cs_sync_q     <= '1;
      din_sync_q    <= '0;
      sclk_prev_q   <= 1'b0;
      cs_prev_q     <= 1'b1;
      fill_q        <= '0;
      armed_q       <= 1'b0;
      tx_q          <= '0;
      rx_q          <= '0;
      bit_cnt_q     <= '0;
      next_ch_q     <= RESET_CHANNEL;
      frame_count_q <= '0;
      dout_q        <= 1'b0;
      frame_error_q <= 1'b0;
      // NOTE: the sample register file is only eight words and must read back
      // as zero after reset, so it is reset like ordinary flops.
      for (int i = 0; i < 8; i++) value_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      sclk_sync_q   <= sclk_sync_d;
      cs_sync_q     <= cs_sync_d;
      din_sync_q    <= din_sync_d;
      sclk_prev_q   <= sclk_prev_d;
      cs_prev_q     <= cs_prev_d;
      fill_q        <= fill_d;
      armed_q       <= armed_d;
      tx_q          <= tx_d;
      rx_q          <= rx_d;
      bit_cnt_q     <= bit_cnt_d;
      next_ch_q     <= next_ch_d;
      frame_count_q <= frame_count_d;
      dout_q        <= dout_d;
      frame_error_q <= frame_error_d;
      for (int i = 0; i < 8; i++) value_q[i] <= value_d[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. cs_n edges are tested first so they win over a
  // simultaneous sclk edge.
  // ---------------------------------------------------------------------------
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cs_fall) state_d = SHIFT;
      SHIFT: begin
        if (cs_rise)        state_d = IDLE;
        else if (last_rise) state_d = DONE;
      end
      DONE:    if (cs_rise) state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    sclk_sync_d   = {sclk_sync_q[SYNC_STAGES-2:0], adc_sclk};
    cs_sync_d     = {cs_sync_q[SYNC_STAGES-2:0],   adc_cs_n};
    din_sync_d    = {din_sync_q[SYNC_STAGES-2:0],  adc_din};
    sclk_prev_d   = sclk_s;
    cs_prev_d     = cs_s;
    // fill_q reaches SYNC_STAGES once the chain output is a genuine pin sample.
    fill_d        = (fill_q == FILL_W'(SYNC_STAGES)) ? fill_q : fill_q + 1'b1;
    armed_d       = armed_q | ((fill_q == FILL_W'(SYNC_STAGES)) & cs_s);
    tx_d          = tx_q;
    rx_d          = rx_q;
    bit_cnt_d     = bit_cnt_q;
    next_ch_d     = next_ch_q;
    frame_count_d = frame_count_q;
    dout_d        = dout_q;
    frame_error_d = 1'b0;
    value_d       = value_q;

    // The snapshot below reads value_q, so a same-cycle write only affects
    // later frames.
    if (avs.write) value_d[avs.address] = avs.writedata[11:0];

    unique case (state_q)
      IDLE: begin
        dout_d = 1'b0;
        if (cs_fall) begin
          tx_d      = {1'b0, next_ch_q, value_q[next_ch_q]};
          dout_d    = tx_d[15];
          bit_cnt_d = '0;
          rx_d      = '0;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          frame_error_d = 1'b1;
          dout_d        = 1'b0;
        end else if (sclk_rise) begin
          rx_d      = {rx_q[14:0], din_s};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (last_rise) dout_d = 1'b0;
        end else if (sclk_fall && bit_cnt_q != '0) begin
          tx_d   = {tx_q[14:0], 1'b0};
          dout_d = tx_d[15];
        end
      end
      DONE: begin
        dout_d = 1'b0;
        if (cs_rise) begin
          if (rx_q[15]) next_ch_d = rx_q[12:10];
          frame_count_d = frame_count_q + 16'd1;
        end
      end
      default: dout_d = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_adc_serial_responder.sv
// -----------------------------------------------------------------------------
// tb_adc_serial_responder
//
// Directed bench for adc_serial_responder: acts as the ADC controller on the
// serial pins and as the processor on the Avalon bus, comparing every observed
// value with a hand-computed expectation.
// -----------------------------------------------------------------------------
module tb_adc_serial_responder;

  localparam int HALF = 6;  // sclk half period in system clocks

  logic        clock;
  logic        reset;
  logic        adc_sclk;
  logic        adc_cs_n;
  logic        adc_din;
  logic        adc_dout;
  logic [15:0] frame_count;
  logic        frame_error;

  int checks  = 0;
  int errors  = 0;
  int err_pulses = 0;

  adc_serial_responder_if bus ();

  adc_serial_responder dut (
    .clock       (clock),
    .reset       (reset),
    .avs         (bus.slave),
    .adc_sclk    (adc_sclk),
    .adc_cs_n    (adc_cs_n),
    .adc_din     (adc_din),
    .adc_dout    (adc_dout),
    .frame_count (frame_count),
    .frame_error (frame_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Counts clock cycles with frame_error high; a correct abort adds exactly 1.
  always @(negedge clock) if (frame_error) err_pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic avalon_write(input logic [2:0] addr, input logic [31:0] data);
    @(negedge clock);
    bus.write     = 1'b1;
    bus.address   = addr;
    bus.writedata = data;
    @(negedge clock);
    bus.write     = 1'b0;
  endtask

  task automatic avalon_read(input logic [2:0] addr, output logic [31:0] data);
    @(negedge clock);
    bus.read    = 1'b1;
    bus.address = addr;
    #1 data     = bus.readdata;
    bus.read    = 1'b0;
  endtask

  // One controller frame: dout is sampled just before each sclk rise, din is
  // changed on each sclk fall. Optionally writes value[3] after rise wr_at.
  task automatic run_frame(input logic [15:0] din_word, input int rises, input int wr_at,
                           input logic [11:0] wr_val, output logic [15:0] word,
                           output logic tail);
    logic [15:0] sh;
    sh   = din_word;
    word = '0;
    tail = 1'b0;
    @(negedge clock);
    adc_cs_n = 1'b0;
    adc_din  = sh[15];
    wait_clks(HALF);
    for (int i = 0; i < rises; i++) begin
      if (i < 16) word[15-i] = adc_dout;
      else        tail = tail | adc_dout;
      adc_sclk = 1'b1;
      wait_clks(HALF);
      if (i + 1 == wr_at) avalon_write(3'd3, {20'h0, wr_val});
      adc_sclk = 1'b0;
      sh       = sh << 1;
      adc_din  = sh[15];
      wait_clks(HALF);
    end
    adc_cs_n = 1'b1;
    wait_clks(2 * HALF);
  endtask

  initial begin
    logic [31:0] rd;
    logic [15:0] word;
    logic        tail;
    logic        dout_seen;

    reset         = 1'b1;
    adc_sclk      = 1'b0;
    adc_cs_n      = 1'b1;
    adc_din       = 1'b0;
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.address   = 3'd0;
    bus.writedata = 32'h0;

    // Reset state
    wait_clks(4);
    check("reset_dout",        {31'b0, adc_dout},    32'h0);
    check("reset_frame_count", {16'b0, frame_count}, 32'h0);
    check("reset_frame_error", {31'b0, frame_error}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    wait_clks(4);

    // Register file access
    avalon_write(3'd3, 32'h00FF_FABC);
    avalon_read(3'd3, rd);
    check("read_addr3", rd, 32'h0000_0ABC);
    avalon_read(3'd2, rd);
    check("read_addr2", rd, 32'h0000_0000);
    @(negedge clock);
    bus.address = 3'd3;
    #1 check("readdata_idle", bus.readdata, 32'h0000_0000);

    // Pipelined channel selection
    avalon_write(3'd0, 32'h0000_0123);
    run_frame(16'h8C00, 16, 0, 12'h0, word, tail);
    check("frame1_word", {16'b0, word},        32'h0000_0123);
    check("frame1_count", {16'b0, frame_count}, 32'd1);
    run_frame(16'h0000, 16, 0, 12'h0, word, tail);
    check("frame2_word", {16'b0, word},        32'h0000_3ABC);
    check("frame2_count", {16'b0, frame_count}, 32'd2);
    run_frame(16'h0000, 16, 0, 12'h0, word, tail);
    check("frame3_word", {16'b0, word},        32'h0000_3ABC);
    check("frame3_count", {16'b0, frame_count}, 32'd3);
    check("no_error_yet", err_pulses, 32'd0);

    // Aborted frame carrying a WRITE to channel 7 that must be discarded
    run_frame(16'h9C00, 9, 0, 12'h0, word, tail);
    check("abort_pulse_cycles", err_pulses, 32'd1);
    check("abort_count", {16'b0, frame_count}, 32'd3);
    run_frame(16'h0000, 16, 0, 12'h0, word, tail);
    check("after_abort_word", {16'b0, word}, 32'h0000_3ABC);
    check("after_abort_count", {16'b0, frame_count}, 32'd4);

    // Avalon write during a frame affects only the next frame
    run_frame(16'h0000, 16, 4, 12'h555, word, tail);
    check("midwrite_word", {16'b0, word}, 32'h0000_3ABC);
    run_frame(16'h0000, 16, 0, 12'h0, word, tail);
    check("postwrite_word", {16'b0, word}, 32'h0000_3555);
    check("postwrite_count", {16'b0, frame_count}, 32'd6);

    // Reset in the middle of a frame, cs_n held low across release
    @(negedge clock);
    adc_cs_n = 1'b0;
    wait_clks(HALF);
    for (int i = 0; i < 6; i++) begin
      adc_sclk = 1'b1;
      wait_clks(HALF);
      adc_sclk = 1'b0;
      wait_clks(HALF);
    end
    reset = 1'b1;
    wait_clks(3);
    check("midreset_dout",  {31'b0, adc_dout},    32'h0);
    check("midreset_count", {16'b0, frame_count}, 32'h0);
    avalon_read(3'd3, rd);
    check("midreset_value3", rd, 32'h0);
    @(negedge clock);
    reset         = 1'b0;
    bus.write     = 1'b1;
    bus.address   = 3'd0;
    bus.writedata = 32'h0000_0FFF;
    @(negedge clock);
    bus.write     = 1'b0;
    dout_seen     = 1'b0;
    for (int k = 0; k < 72; k++) begin
      @(negedge clock);
      if (k % 12 == 0) adc_sclk = 1'b1;
      if (k % 12 == 6) adc_sclk = 1'b0;
      dout_seen = dout_seen | adc_dout;
    end
    check("held_cs_no_dout", {31'b0, dout_seen}, 32'h0);
    check("held_cs_no_error", err_pulses, 32'd1);
    adc_cs_n = 1'b1;
    wait_clks(2 * HALF);
    run_frame(16'h0000, 16, 0, 12'h0, word, tail);
    check("postreset_word",  {16'b0, word},        32'h0000_0FFF);
    check("postreset_count", {16'b0, frame_count}, 32'd1);

    // Counter wrap from a preloaded value
    @(negedge clock);
    force dut.frame_count_q = 16'hFFFF;
    @(negedge clock);
    release dut.frame_count_q;
    check("preload_count", {16'b0, frame_count}, 32'h0000_FFFF);
    run_frame(16'h0000, 16, 0, 12'h0, word, tail);
    check("wrap_word",  {16'b0, word},        32'h0000_0FFF);
    check("wrap_count", {16'b0, frame_count}, 32'h0000_0000);

    // Over-long frame: extra sclk rises are ignored
    run_frame(16'h0000, 20, 0, 12'h0, word, tail);
    check("long_word",     {16'b0, word},        32'h0000_0FFF);
    check("long_tail",     {31'b0, tail},        32'h0);
    check("long_no_error", err_pulses,           32'd1);
    check("long_count",    {16'b0, frame_count}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
